// File: rtl/adc_sample_scheduler.sv
// Round-robin ADC sample scheduler with per-channel ring-buffer write addressing.
// Define ADC_SAMPLE_TAG_EN to stamp the channel number into the top 4 bits of each word.
module adc_sample_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 640,
    parameter int BASE_ADDR = 'h801,
    parameter int INTERVAL  = 125000,
    parameter int CNT_W     = 18,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_ready,
    output logic [CH_W-1:0]          cur_ch,
    output logic                     lap_done,
    output logic                     overrun
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx [NUM_CH];
    logic               tick;
    logic               capture;
    logic               accept;
    logic [DATA_W-1:0]  sample_sel;
    logic [ADDR_W-1:0]  addr_next;

    function automatic logic [DATA_W-1:0] format_sample(input logic [DATA_W-1:0] raw);
`ifdef ADC_SAMPLE_TAG_EN
        return {4'(cur_ch), raw[DATA_W-5:0]};
`else
        return raw;
`endif
    endfunction

    assign tick    = enable && (cnt == CNT_W'(INTERVAL - 1));
    assign capture = (state == IDLE) && tick;
    assign accept  = (state == WRITE) && wr_ready;
    assign wr_en   = (state == WRITE);

    always_comb begin
        sample_sel = ch_data[32'(cur_ch)*DATA_W +: DATA_W];
        addr_next  = ADDR_W'(BASE_ADDR) + ADDR_W'(32'(cur_ch) * DEPTH) + ADDR_W'(idx[cur_ch]);
    end

    always_ff @(posedge clock) begin
        if (reset || !enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick)     state_next = WRITE;
            WRITE:   if (wr_ready) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // A tick while a write is outstanding (even in its acceptance cycle) is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr  <= '0;
            wr_data  <= '0;
            cur_ch   <= '0;
            lap_done <= 1'b0;
            overrun  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                idx[c] <= '0;
        end else begin
            lap_done <= 1'b0;
            if (capture) begin
                wr_addr <= addr_next;
                wr_data <= format_sample(sample_sel);
            end
            if (accept) begin
                idx[cur_ch] <= (idx[cur_ch] == IDX_W'(DEPTH - 1)) ? '0 : idx[cur_ch] + 1'b1;
                cur_ch      <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
                lap_done    <= (cur_ch == CH_W'(NUM_CH - 1)) && (idx[cur_ch] == IDX_W'(DEPTH - 1));
            end
            if (tick && state == WRITE)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler: directed scenarios plus randomized traffic against a write-count model.
module tb_adc_sample_scheduler;

    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 3;
    localparam int BASE     = 'h801;
    localparam int INTERVAL = 4;
    localparam int CNT_W    = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic                     enable;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_ready;
    logic [0:0]               cur_ch;
    logic                     lap_done;
    logic                     overrun;

    adc_sample_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .BASE_ADDR(BASE), .INTERVAL(INTERVAL), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .cur_ch(cur_ch), .lap_done(lap_done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Reference state: cycles since the interval restarted, and number of accepted writes.
    int                m_phase;
    int                m_nacc;
    bit                m_busy;
    bit                m_ovr;
    bit                m_lap;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;

    int vectors     = 0;
    int miscompares = 0;
    int lap_pulses  = 0;

    function automatic logic [DATA_W-1:0] expect_word(input int ch, input logic [DATA_W-1:0] s);
`ifdef ADC_SAMPLE_TAG_EN
        return {4'(ch), s[DATA_W-5:0]};
`else
        return s;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit tick, accept;
        int ch, lap_len;
        logic [DATA_W-1:0] s;
        lap_len = NUM_CH * DEPTH;
        if (reset) begin
            m_phase = 0; m_nacc = 0; m_busy = 0; m_ovr = 0; m_lap = 0;
            m_addr = '0; m_data = '0;
            return;
        end
        tick   = enable && (m_phase == INTERVAL - 1);
        accept = m_busy && wr_ready;
        m_lap  = accept && ((m_nacc % lap_len) == lap_len - 1);
        if (tick && m_busy)
            m_ovr = 1;
        if (tick && !m_busy) begin
            ch     = m_nacc % NUM_CH;
            s      = ch_data[ch*DATA_W +: DATA_W];
            m_addr = ADDR_W'(BASE + ch*DEPTH + (m_nacc / NUM_CH) % DEPTH);
            m_data = expect_word(ch, s);
            m_busy = 1;
        end else if (accept) begin
            m_busy = 0;
            m_nacc++;
        end
        m_phase = (!enable || tick) ? 0 : m_phase + 1;
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("wr_en",    32'(wr_en),    32'(m_busy));
        check("wr_addr",  32'(wr_addr),  32'(m_addr));
        check("wr_data",  32'(wr_data),  32'(m_data));
        check("cur_ch",   32'(cur_ch),   32'(m_nacc % NUM_CH));
        check("lap_done", 32'(lap_done), 32'(m_lap));
        check("overrun",  32'(overrun),  32'(m_ovr));
        if (lap_done === 1'b1)
            lap_pulses++;
    endtask

    task automatic wait_request(input string tag);
        for (int i = 0; i < 3 * INTERVAL && wr_en !== 1'b1; i++)
            step();
        check(tag, 32'(wr_en), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        wr_ready = 1'b1;
`ifdef ADC_SAMPLE_TAG_EN
        ch_data  = {32'hFFFF_FFFF, 32'h0000_0111};
`else
        ch_data  = {32'h0000_0222, 32'h0000_0111};
`endif
        step();
        step();

        // First write arrives four cycles after reset release.
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("first_wr_en",   32'(wr_en),   32'd1);
        check("first_wr_addr", 32'(wr_addr), 32'h801);
        for (int i = 0; i < 4; i++) step();
        check("second_wr_addr", 32'(wr_addr), 32'h804);
`ifdef ADC_SAMPLE_TAG_EN
        check("second_wr_data", 32'(wr_data), 32'h1FFF_FFFF);
`else
        check("second_wr_data", 32'(wr_data), 32'h222);
`endif

        // Twelve back-to-back ticks: two full laps of both rings.
        lap_pulses = 0;
        for (int i = 0; i < 12 * INTERVAL; i++) step();
        check("lap_pulses", 32'(lap_pulses), 32'd2);

        // Stalled RAM: request stays frozen and the intervening tick is lost.
        wait_request("stall_wait");
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ch_data = {$urandom(), $urandom()};
            step();
        end
        check("stall_overrun", 32'(overrun), 32'd1);
        wr_ready = 1'b1;
        for (int i = 0; i < 2 * INTERVAL; i++) step();

        // Enable low mid-interval holds off ticks; the interval restarts on re-enable.
        step();
        enable = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("disabled_idle", 32'(wr_en), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("reenable_early", 32'(wr_en), 32'd0);
        step();
        check("reenable_write", 32'(wr_en), 32'd1);

        // Reset while a write is pending drops it.
        for (int i = 0; i < 2 * INTERVAL; i++) step();
        wait_request("reset_wait");
        reset = 1'b1;
        step();
        check("reset_wr_en", 32'(wr_en), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("post_reset_addr", 32'(wr_addr), 32'h801);

        // Randomized traffic: sample data, back-pressure, enable and occasional reset.
        for (int i = 0; i < 800; i++) begin
            ch_data  = {$urandom(), $urandom()};
            wr_ready = ($urandom_range(0, 3) != 0);
            enable   = ($urandom_range(0, 15) != 0);
            reset    = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
